// File: rtl/fifo_sync_cfg.sv
`default_nettype none
//==============================================================================
// Module   : fifo_sync_cfg
// Purpose  : Single-clock parametrised FIFO with selectable standard or
//            first-word-fall-through read, occupancy count, programmable
//            almost-full/almost-empty thresholds and sticky overflow/underflow
//            error flags. Both ports share one clock, so no pointer
//            synchronisation is needed.
// Ports    : i_clk            rising-edge clock
//            i_rst            synchronous active-high reset
//            i_wr_inc         write request
//            i_wr_data        write data
//            i_rd_inc         read/pop request
//            i_clr_err        clears o_overflow / o_underflow
//            o_rd_data        read data
//            o_rd_valid       o_rd_data qualifier
//            o_full           count == DEPTH
//            o_empty          count == 0
//            o_almost_full    count >= AFULL_LVL
//            o_almost_empty   count <= AEMPTY_LVL
//            o_count          words stored, 0..DEPTH
//            o_overflow       sticky: write attempted while full
//            o_underflow      sticky: read attempted while empty
// Revision : 1.0  initial release
//==============================================================================
module fifo_sync_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3,
   parameter int AFULL_LVL  = 6,
   parameter int AEMPTY_LVL = 1,
   parameter int FWFT       = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_wr_inc,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_inc,
   input  logic                  i_clr_err,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_rd_valid,
   output logic                  o_full,
   output logic                  o_empty,
   output logic                  o_almost_full,
   output logic                  o_almost_empty,
   output logic [ADDR_WIDTH:0]   o_count,
   output logic                  o_overflow,
   output logic                  o_underflow
);

   localparam int                  c_DEPTH     = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = c_DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_AFULL     = AFULL_LVL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_AEMPTY    = AEMPTY_LVL[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] c_CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
   logic [ADDR_WIDTH-1:0] r_wptr;
   logic [ADDR_WIDTH-1:0] r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  r_full;
   logic                  r_empty;
   logic                  r_almost_full;
   logic                  r_almost_empty;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // Acceptance looks only at the registered flags, so a pop in the same
   // cycle never makes room for a write into a full FIFO (and vice versa).
   assign w_wr_acc = i_wr_inc & ~r_full;
   assign w_rd_acc = i_rd_inc & ~r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_count_nxt = r_count + c_CNT_ONE;
      end else if (!w_wr_acc && w_rd_acc) begin
         w_count_nxt = r_count - c_CNT_ONE;
      end
   end

   // Storage has no reset: after a reset the pointers make old words unreachable.
   always_ff @(posedge i_clk) begin
      if (!i_rst && w_wr_acc) begin
         r_mem[r_wptr] <= i_wr_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_count        <= '0;
         r_full         <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_full  <= 1'b0;
         r_almost_empty <= 1'b1;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wptr <= r_wptr + c_PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rptr <= r_rptr + c_PTR_ONE;
         end
         r_count        <= w_count_nxt;
         r_full         <= (w_count_nxt == c_DEPTH_CNT);
         r_empty        <= (w_count_nxt == '0);
         r_almost_full  <= (w_count_nxt >= c_AFULL);
         r_almost_empty <= (w_count_nxt <= c_AEMPTY);
         // A new error in the same cycle as a clear keeps the flag set.
         r_overflow     <= (i_wr_inc & r_full)  | (r_overflow  & ~i_clr_err);
         r_underflow    <= (i_rd_inc & r_empty) | (r_underflow & ~i_clr_err);
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented continuously; a pop advances to the next.
         assign o_rd_data  = r_mem[r_rptr];
         assign o_rd_valid = ~r_empty;
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_rd_data;
         logic                  r_rd_valid;

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_rd_data  <= '0;
               r_rd_valid <= 1'b0;
            end else begin
               r_rd_valid <= w_rd_acc;
               if (w_rd_acc) begin
                  r_rd_data <= r_mem[r_rptr];
               end
            end
         end

         assign o_rd_data  = r_rd_data;
         assign o_rd_valid = r_rd_valid;
      end
   endgenerate

   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_almost_full  = r_almost_full;
   assign o_almost_empty = r_almost_empty;
   assign o_count        = r_count;
   assign o_overflow     = r_overflow;
   assign o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_cfg.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_sync_cfg
// Purpose  : Self-checking bench for fifo_sync_cfg. Two instances (standard
//            and first-word-fall-through) share one stimulus stream; a queue
//            model of the FIFO contents predicts count, flags and error bits,
//            and a scoreboard of expected read words is popped whenever the
//            standard-mode instance presents valid read data.
// Revision : 1.0  initial release
//==============================================================================
module tb_fifo_sync_cfg;

   localparam int c_DW    = 8;
   localparam int c_AW    = 3;
   localparam int c_DEPTH = 8;
   localparam int c_AFULL = 6;
   localparam int c_AEMPT = 1;

   logic            clk;
   logic            i_rst;
   logic            i_wr_inc;
   logic [c_DW-1:0] i_wr_data;
   logic            i_rd_inc;
   logic            i_clr_err;

   logic [c_DW-1:0] w_rd_data0,  w_rd_data1;
   logic            w_rd_valid0, w_rd_valid1;
   logic            w_full0,  w_full1;
   logic            w_empty0, w_empty1;
   logic            w_afull0, w_afull1;
   logic            w_aempt0, w_aempt1;
   logic [c_AW:0]   w_count0, w_count1;
   logic            w_ovf0,   w_ovf1;
   logic            w_udf0,   w_udf1;

   fifo_sync_cfg #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .AFULL_LVL(c_AFULL),
                   .AEMPTY_LVL(c_AEMPT), .FWFT(0)) u_dut_std (
      .i_clk(clk), .i_rst(i_rst), .i_wr_inc(i_wr_inc), .i_wr_data(i_wr_data),
      .i_rd_inc(i_rd_inc), .i_clr_err(i_clr_err),
      .o_rd_data(w_rd_data0), .o_rd_valid(w_rd_valid0), .o_full(w_full0),
      .o_empty(w_empty0), .o_almost_full(w_afull0), .o_almost_empty(w_aempt0),
      .o_count(w_count0), .o_overflow(w_ovf0), .o_underflow(w_udf0)
   );

   fifo_sync_cfg #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW), .AFULL_LVL(c_AFULL),
                   .AEMPTY_LVL(c_AEMPT), .FWFT(1)) u_dut_fwft (
      .i_clk(clk), .i_rst(i_rst), .i_wr_inc(i_wr_inc), .i_wr_data(i_wr_data),
      .i_rd_inc(i_rd_inc), .i_clr_err(i_clr_err),
      .o_rd_data(w_rd_data1), .o_rd_valid(w_rd_valid1), .o_full(w_full1),
      .o_empty(w_empty1), .o_almost_full(w_afull1), .o_almost_empty(w_aempt1),
      .o_count(w_count1), .o_overflow(w_ovf1), .o_underflow(w_udf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_vec;
   int unsigned n_err;

   // Reference model state
   logic [c_DW-1:0] m_fifo[$];    // words held, head at index 0
   logic [c_DW-1:0] m_exp_rd[$];  // scoreboard: words the standard port owes
   logic            m_rd_valid;
   logic            m_ovf;
   logic            m_udf;
   logic [c_DW-1:0] m_last_rd;    // standard-mode RD_DATA holds this

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic check_outputs();
      logic [c_DW-1:0] w_exp;
      int              cnt;
      cnt = m_fifo.size();
      chk("count_std",   32'(w_count0), 32'(cnt));
      chk("count_fwft",  32'(w_count1), 32'(cnt));
      chk("full",        32'(w_full0),  32'(cnt == c_DEPTH));
      chk("empty",       32'(w_empty0), 32'(cnt == 0));
      chk("afull",       32'(w_afull0), 32'(cnt >= c_AFULL));
      chk("aempty",      32'(w_aempt0), 32'(cnt <= c_AEMPT));
      chk("flags_fwft",  {28'd0, w_full1, w_empty1, w_afull1, w_aempt1},
                         {28'd0, w_full0 == 1'b1 ? 1'b1 : 1'b0, cnt == 0, cnt >= c_AFULL, cnt <= c_AEMPT} &
                         {28'd0, cnt == c_DEPTH, 3'b111});
      chk("overflow",    {30'd0, w_ovf1, w_ovf0}, {30'd0, m_ovf, m_ovf});
      chk("underflow",   {30'd0, w_udf1, w_udf0}, {30'd0, m_udf, m_udf});
      chk("rd_valid_std", 32'(w_rd_valid0), 32'(m_rd_valid));
      if (w_rd_valid0) begin
         if (m_exp_rd.size() == 0) begin
            chk("rd_data_std_unexpected", 32'(w_rd_data0), 32'hFFFF_FFFF);
         end else begin
            w_exp = m_exp_rd.pop_front();
            m_last_rd = w_exp;
            chk("rd_data_std", 32'(w_rd_data0), 32'(w_exp));
         end
      end else begin
         chk("rd_data_hold", 32'(w_rd_data0), 32'(m_last_rd));
      end
      chk("rd_valid_fwft", 32'(w_rd_valid1), 32'(cnt != 0));
      if (cnt != 0) begin
         chk("rd_data_fwft", 32'(w_rd_data1), 32'(m_fifo[0]));
      end
   endtask

   // One clock cycle: drive requests, let the edge happen, advance the
   // model with pre-edge state, then compare 1 time unit after the edge.
   task automatic step(input logic rst, input logic wr, input logic [c_DW-1:0] d,
                       input logic rd, input logic clr);
      logic full_pre, empty_pre, wa, ra;
      i_rst     = rst;
      i_wr_inc  = wr;
      i_wr_data = d;
      i_rd_inc  = rd;
      i_clr_err = clr;
      @(posedge clk);
      if (rst) begin
         m_fifo.delete();
         m_exp_rd.delete();
         m_rd_valid = 1'b0;
         m_ovf      = 1'b0;
         m_udf      = 1'b0;
         m_last_rd  = '0;
      end else begin
         full_pre  = (m_fifo.size() == c_DEPTH);
         empty_pre = (m_fifo.size() == 0);
         wa = wr & ~full_pre;
         ra = rd & ~empty_pre;
         m_rd_valid = ra;
         if (ra) m_exp_rd.push_back(m_fifo.pop_front());
         if (wa) m_fifo.push_back(d);
         m_ovf = (wr & full_pre)  | (m_ovf & ~clr);
         m_udf = (rd & empty_pre) | (m_udf & ~clr);
      end
      #1;
      check_outputs();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_rd_valid = 1'b0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_last_rd = '0;
      i_rst = 1'b1; i_wr_inc = 1'b0; i_wr_data = '0; i_rd_inc = 1'b0; i_clr_err = 1'b0;

      // Reset state
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Fill with 0x11..0x88
      for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 8'(k * 8'h11), 1'b0, 1'b0);

      // Write+read while full: read accepted, write rejected, overflow set
      step(1'b0, 1'b1, 8'h99, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      // Refill, then error and clear in the same cycle: set must win
      step(1'b0, 1'b1, 8'h99, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Drain completely plus one extra read (underflow)
      for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

      // Wrap: 3 rounds of 5 writes / 5 reads
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'h40 + r * 5 + k), 1'b0, 1'b0);
         for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Fall-through: write to empty, then simultaneous pop/push at count 1
      step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Mid-operation reset together with a write request
      for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 8'(8'hC0 + k), 1'b0, 1'b0);
      step(1'b0, 1'b1, 8'hDD, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
      chk("rd_data_after_rst", 32'(w_rd_data0), 32'h0);
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      // Random mixed traffic
      for (int k = 0; k < 400; k++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
